mem_ctrl: RTL

Memory controller between the core's two memory clients and the byte-wide unified RAM. The instruction-fetch unit and the load/store buffer each present word-level requests. The block arbitrates between them and serialises every request into single-byte RAM cycles. Load and fetch data are returned as assembled 32-bit words. Store data is written one byte per cycle under the byte mask.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_byte_seq.sv | 75 +++++++
 rtl/mem_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and constants for the byte-serialising memory controller.
//   state_t  : controller FSM states
//   client_t : owner of the transfer in flight
//   WORD_BYTES / CNT_WIDTH : word size in bytes and width of the lane counter
package mem_ctrl_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_WIDTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT_LAST,
        WRITE
    } state_t;

    typedef enum logic {
        CLIENT_IF,
        CLIENT_LSB
    } client_t;

endpackage

// File: rtl/mem_byte_seq.sv
// mem_byte_seq
// Byte serialiser datapath: 2-bit lane counter, read-word assembly and
// store-lane selection.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cnt_clr, cnt_inc      clear / advance the lane counter (clear wins)
//   cnt                   current lane counter
//   cap_en, din           capture din into lane (cnt - 1) of the read word
//   word_next             read word including this cycle's capture
//   sel_lane, sel_data,
//   sel_mask              lane index, source word and byte mask for stores
//   sel_byte, sel_en      selected store byte and its write enable
module mem_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_clr,
    input  logic                 cnt_inc,
    output logic [CNT_WIDTH-1:0] cnt,
    input  logic                 cap_en,
    input  logic [7:0]           din,
    output logic [31:0]          word_next,
    input  logic [CNT_WIDTH-1:0] sel_lane,
    input  logic [31:0]          sel_data,
    input  logic [3:0]           sel_mask,
    output logic [7:0]           sel_byte,
    output logic                 sel_en
);

    logic [31:0]          word_q;
    logic [CNT_WIDTH-1:0] cap_lane;

    // RAM data lags the address by one cycle, so the byte arriving now
    // belongs to the lane issued last cycle. In WAIT_LAST the counter has
    // already wrapped to 0, and 0 - 1 conveniently selects lane 3.
    assign cap_lane = cnt - CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        word_next = word_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (cap_en && (cap_lane == CNT_WIDTH'(i))) begin
                word_next[8*i +: 8] = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_next;
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (sel_lane == CNT_WIDTH'(i)) begin
                sel_byte = sel_data[8*i +: 8];
            end
        end
    end

    assign sel_en = sel_mask[sel_lane];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Arbitrates the load/store buffer (priority) and instruction fetch onto a
// byte-wide RAM, serialising each word request into four byte cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   flush                             aborts in-flight reads, blocks accept
//   lsb_req/we/addr/wdata/mask        LSB request (store or load)
//   lsb_ready, lsb_rvalid, lsb_rdata  LSB handshake and load result
//   if_req/addr                       fetch request
//   if_ready, if_rvalid, if_rdata     fetch handshake and result
//   ram_a, ram_wr, ram_dout, ram_din  registered RAM port (din lags a by 1)
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  lsb_req,
    input  logic                  lsb_we,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    input  logic [3:0]            lsb_mask,
    output logic                  lsb_ready,
    output logic                  lsb_rvalid,
    output logic [31:0]           lsb_rdata,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    state_t                state, state_nxt;
    client_t               client;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata_q;
    logic [3:0]            mask_q;

    logic                  lsb_accept, if_accept, accept, abort, done;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [CNT_WIDTH-1:0]  cnt, lane_nxt, sel_lane;
    logic                  cnt_last, cnt_clr, cnt_inc, cap_en;
    logic [31:0]           word_next, sel_data;
    logic [3:0]            sel_mask;
    logic [7:0]            sel_byte;
    logic                  sel_en;
    logic [ADDR_WIDTH-1:0] ram_a_nxt;
    logic                  ram_wr_nxt;
    logic [7:0]            ram_dout_nxt;

    assign lsb_ready  = (state == IDLE) && !flush;
    assign if_ready   = (state == IDLE) && !flush && !lsb_req;
    assign lsb_accept = lsb_req && lsb_ready;
    assign if_accept  = if_req && if_ready;
    assign accept     = lsb_accept || if_accept;
    assign req_addr   = lsb_accept ? lsb_addr : if_addr;

    assign abort    = flush && ((state == READ) || (state == WAIT_LAST));
    assign done     = (state == WAIT_LAST) && !flush;
    assign cnt_last = (cnt == CNT_WIDTH'(WORD_BYTES - 1));
    assign lane_nxt = cnt + CNT_WIDTH'(1);

    // The first store lane is issued on the accept edge, before the request
    // is latched, so it is taken straight from the LSB inputs.
    assign sel_lane = (state == IDLE) ? '0 : lane_nxt;
    assign sel_data = (state == IDLE) ? lsb_wdata : wdata_q;
    assign sel_mask = (state == IDLE) ? lsb_mask : mask_q;

    assign cnt_clr = accept || abort;
    assign cnt_inc = ((state == READ) && !flush) || (state == WRITE);
    assign cap_en  = ((state == READ) && (cnt != '0)) || (state == WAIT_LAST);

    mem_byte_seq u_seq (
        .clk       (clk),
        .rst       (rst),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .cnt       (cnt),
        .cap_en    (cap_en),
        .din       (ram_din),
        .word_next (word_next),
        .sel_lane  (sel_lane),
        .sel_data  (sel_data),
        .sel_mask  (sel_mask),
        .sel_byte  (sel_byte),
        .sel_en    (sel_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (lsb_accept) begin
                    state_nxt = lsb_we ? WRITE : READ;
                end else if (if_accept) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt_last) begin
                    state_nxt = WAIT_LAST;
                end
            end
            WAIT_LAST: state_nxt = IDLE;
            WRITE: begin
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM outputs are registered, so this computes the values for the next
    // cycle: the lane after the current one while a transfer is running.
    always_comb begin
        ram_a_nxt    = ram_a;
        ram_wr_nxt   = 1'b0;
        ram_dout_nxt = ram_dout;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ram_a_nxt = req_addr & ~ADDR_WIDTH'(3);
                end
                if (lsb_accept && lsb_we) begin
                    ram_wr_nxt   = sel_en;
                    ram_dout_nxt = sel_byte;
                end
            end
            READ: begin
                if (!flush && !cnt_last) begin
                    ram_a_nxt = base + ADDR_WIDTH'(lane_nxt);
                end
            end
            WRITE: begin
                if (!cnt_last) begin
                    ram_a_nxt    = base + ADDR_WIDTH'(lane_nxt);
                    ram_wr_nxt   = sel_en;
                    ram_dout_nxt = sel_byte;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_a      <= '0;
            ram_wr     <= 1'b0;
            ram_dout   <= 8'h00;
            lsb_rvalid <= 1'b0;
            if_rvalid  <= 1'b0;
            lsb_rdata  <= 32'h0;
            if_rdata   <= 32'h0;
            base       <= '0;
            client     <= CLIENT_IF;
            wdata_q    <= 32'h0;
            mask_q     <= 4'h0;
        end else begin
            ram_a      <= ram_a_nxt;
            ram_wr     <= ram_wr_nxt;
            ram_dout   <= ram_dout_nxt;
            lsb_rvalid <= done && (client == CLIENT_LSB);
            if_rvalid  <= done && (client == CLIENT_IF);
            if (done && (client == CLIENT_LSB)) begin
                lsb_rdata <= word_next;
            end
            if (done && (client == CLIENT_IF)) begin
                if_rdata <= word_next;
            end
            if (accept) begin
                base    <= req_addr & ~ADDR_WIDTH'(3);
                client  <= lsb_accept ? CLIENT_LSB : CLIENT_IF;
                wdata_q <= lsb_wdata;
                mask_q  <= lsb_mask;
            end
        end
    end

endmodule
